// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register carrying data and control as one entry, with a
// valid/ready handshake, an optional skid entry, flush/bubble control and stall statistics.
module pipe_stage_skid #(
   parameter int DATA_W = 160,
   parameter int CTRL_W = 10,
   parameter int SKID   = 1,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              flush,
   input  logic              bubble,
   output logic [1:0]        occupancy,
   output logic [STAT_W-1:0] stall_cnt
);

   localparam bit HAS_SKID = (SKID != 0);

   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   logic              out_free;
   logic              accept;
   logic              drain;

   logic              nxt_out_valid;
   logic [DATA_W-1:0] nxt_out_data;
   logic [CTRL_W-1:0] nxt_out_ctrl;
   logic              nxt_skid_valid;
   logic [DATA_W-1:0] nxt_skid_data;
   logic [CTRL_W-1:0] nxt_skid_ctrl;

   assign out_free = !out_valid || out_ready;

   // With a skid entry the ready path depends only on local state, so upstream
   // stalls never see a combinational path from out_ready.
   assign in_ready = !rst && !flush && !bubble && (HAS_SKID ? !skid_valid : out_free);
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready;

   always_comb begin
      nxt_out_valid  = out_valid;
      nxt_out_data   = out_data;
      nxt_out_ctrl   = out_ctrl;
      nxt_skid_valid = skid_valid;
      nxt_skid_data  = skid_data;
      nxt_skid_ctrl  = skid_ctrl;

      if (flush) begin
         nxt_out_valid  = 1'b0;
         nxt_out_data   = '0;
         nxt_out_ctrl   = '0;
         nxt_skid_valid = 1'b0;
         nxt_skid_data  = '0;
         nxt_skid_ctrl  = '0;
      end else if (skid_valid && out_free) begin
         nxt_out_valid  = 1'b1;
         nxt_out_data   = skid_data;
         nxt_out_ctrl   = skid_ctrl;
         nxt_skid_valid = 1'b0;
         nxt_skid_data  = '0;
         nxt_skid_ctrl  = '0;
      end else if (bubble && out_free) begin
         nxt_out_valid  = 1'b0;
         nxt_out_data   = '0;
         nxt_out_ctrl   = '0;
      end else if (accept && out_free) begin
         nxt_out_valid  = 1'b1;
         nxt_out_data   = in_data;
         nxt_out_ctrl   = in_ctrl;
      end else if (accept && HAS_SKID) begin
         nxt_skid_valid = 1'b1;
         nxt_skid_data  = in_data;
         nxt_skid_ctrl  = in_ctrl;
      end else if (drain) begin
         // data is left in place; only valid and the control word are retired
         nxt_out_valid  = 1'b0;
         nxt_out_ctrl   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_ctrl   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_ctrl  <= '0;
         occupancy  <= 2'd0;
      end else begin
         out_valid  <= nxt_out_valid;
         out_data   <= nxt_out_data;
         out_ctrl   <= nxt_out_ctrl;
         skid_valid <= nxt_skid_valid;
         skid_data  <= nxt_skid_data;
         skid_ctrl  <= nxt_skid_ctrl;
         occupancy  <= {1'b0, nxt_out_valid} + {1'b0, nxt_skid_valid};
      end
   end

   // Saturating stall counter; deliberately unaffected by flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {STAT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + STAT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: scoreboard queue model plus a table of
// hand-derived handshake/occupancy vectors and explicit reset/saturation sequences.
module tb_pipe_stage_skid;

   localparam int DW = 32;
   localparam int CW = 10;
   localparam int SW = 4;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic          flush;
   logic          bubble;
   logic [1:0]    occupancy;
   logic [SW-1:0] stall_cnt;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .STAT_W(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .flush     (flush),
      .bubble    (bubble),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } entry_t;

   typedef struct {
      logic          iv;
      logic [DW-1:0] d;
      logic          orr;
      logic          fl;
      logic          bb;
      logic          ir;
      int            occ;
   } vec_t;

   entry_t        q[$];
   logic [SW-1:0] m_stall;
   int            n_vec;
   int            n_err;
   vec_t          tbl[18];

   function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
      return CW'(d) ^ 10'h200;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      if (q.size() > 0) begin
         chk("out_data", 64'(out_data), 64'(q[0].d));
         chk("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
      end else begin
         chk("out_ctrl_nop", 64'(out_ctrl), 64'd0);
      end
   endtask

   // One clock: drive at posedge+1, check in_ready before the edge, update model, check after.
   task automatic step(input logic iv, input logic [DW-1:0] d, input logic orr,
                       input logic fl, input logic bb, output logic ir_seen);
      logic exp_ir;
      logic acc;
      logic drn;
      entry_t e;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = ctrl_of(d);
      out_ready = orr;
      flush     = fl;
      bubble    = bb;
      #1;
      ir_seen = in_ready;
      exp_ir  = (q.size() < 2) && !fl && !bb;
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      acc = iv && exp_ir;
      drn = (q.size() > 0) && orr;
      if ((q.size() > 0) && !orr && (m_stall != {SW{1'b1}})) m_stall++;
      @(posedge clk);
      #1;
      if (drn) void'(q.pop_front());
      if (fl) q.delete();
      else if (acc) begin
         e.d = d;
         e.c = ctrl_of(d);
         q.push_back(e);
      end
      check_outputs();
   endtask

   initial begin
      logic irs;
      n_vec   = 0;
      n_err   = 0;
      m_stall = '0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_ctrl   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      bubble    = 1'b0;

      // backpressure, flush, bubble, bubble-under-stall, flush+drain
      tbl[0]  = '{1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      tbl[1]  = '{1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
      tbl[2]  = '{1'b1, 32'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
      tbl[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[4]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0};
      tbl[5]  = '{1'b1, 32'hD0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      tbl[6]  = '{1'b1, 32'hE0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
      tbl[7]  = '{1'b1, 32'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      tbl[8]  = '{1'b1, 32'h58, 1'b1, 1'b0, 1'b1, 1'b0, 0};
      tbl[9]  = '{1'b1, 32'h58, 1'b1, 1'b0, 1'b0, 1'b1, 1};
      tbl[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0};
      tbl[11] = '{1'b1, 32'h59, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      tbl[12] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1};
      tbl[13] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 0};
      tbl[14] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0};
      tbl[15] = '{1'b1, 32'h60, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      tbl[16] = '{1'b1, 32'h61, 1'b0, 1'b0, 1'b0, 1'b1, 2};
      tbl[17] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0};

      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      rst = 1'b0;

      // stream 1..8 with free output
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0, irs);
         chk("stream_occ", 64'(occupancy), 64'd1);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, irs);
      chk("stream_stall", 64'(stall_cnt), 64'd0);

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].iv, tbl[i].d, tbl[i].orr, tbl[i].fl, tbl[i].bb, irs);
         chk($sformatf("tbl%0d_ir", i), 64'(irs), 64'(tbl[i].ir));
         chk($sformatf("tbl%0d_occ", i), 64'(occupancy), 64'(tbl[i].occ));
      end
      chk("tbl_stall", 64'(stall_cnt), 64'd6);

      // asynchronous reset with both entries held
      step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, irs);
      step(1'b1, 32'h101, 1'b0, 1'b0, 1'b0, irs);
      in_valid = 1'b1;
      rst      = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_data", 64'(out_data), 64'd0);
      chk("arst_out_ctrl", 64'(out_ctrl), 64'd0);
      chk("arst_occupancy", 64'(occupancy), 64'd0);
      chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd0);
      q.delete();
      m_stall = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_outputs();

      // saturate the stall counter: more than 2^SW+3 stalled cycles
      for (int i = 0; i < 22; i++) step(1'b1, DW'(32'h200 + i), 1'b0, 1'b0, 1'b0, irs);
      chk("sat_stall_cnt", 64'(stall_cnt), 64'hF);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, irs);
      chk("sat_hold", 64'(stall_cnt), 64'hF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
